// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned DIVIDEND_W / DIVISOR_W, one quotient bit per clock (MSB first),
// valid/ready on both sides; divide-by-zero returns all-ones quotient with a flag.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after DIVIDEND_W steps this register holds the quotient.
  logic [DIVIDEND_W-1:0] dq_sh;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W:0]    p;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W+1:0]  p_ext;
  logic [DIVISOR_W:0]    diff;
  logic [DIVISOR_W:0]    p_nxt;
  logic                  q_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    p_ext = {p, dq_sh[DIVIDEND_W-1]};
    q_bit = (p_ext >= {2'b00, dsr});
    diff  = p_ext[DIVISOR_W:0] - {1'b0, dsr};
    p_nxt = q_bit ? diff : p_ext[DIVISOR_W:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_sh       <= '0;
      dsr         <= '0;
      p           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dq_sh <= dividend;
          dsr   <= divisor;
          p     <= '0;
          cnt   <= CNT_W'(DIVIDEND_W - 1);
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end
        end
        RUN: begin
          p     <= p_nxt;
          dq_sh <= {dq_sh[DIVIDEND_W-2:0], q_bit};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            quotient    <= {dq_sh[DIVIDEND_W-2:0], q_bit};
            remainder   <= p_nxt[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed + randomized + exhaustive bench for seq_restoring_divider against
// a plain-arithmetic model (a/b, a%b, all-ones on divide by zero).
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [7:0] prev_q = '0;
  logic       keep_ready = 1'b0;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a/b, wait for the result, hold it `hold` cycles with out_ready low, then hand it off.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int hold, input bit intrude);
    int lat;
    int wt;
    logic [7:0] eq;
    logic [3:0] er;
    eq = (b == 0) ? 8'hFF : 8'(a / b);
    er = (b == 0) ? 4'd0  : 4'(a % b);
    wt = 0;
    while (!in_ready && wt < 20) begin tick(); wt++; end
    check($sformatf("ready_wait %0d/%0d", a, b), 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    tick();                                         // accept edge E0
    in_valid = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    if (b != 0) check($sformatf("q_hold %0d/%0d", a, b), 32'(quotient), 32'(prev_q));
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check($sformatf("latency %0d/%0d", a, b), lat, (b == 0) ? 0 : 8);
    check($sformatf("quot %0d/%0d", a, b), 32'(quotient), 32'(eq));
    check($sformatf("rem %0d/%0d", a, b), 32'(remainder), 32'(er));
    check($sformatf("dbz %0d/%0d", a, b), 32'(div_by_zero), 32'(b == 0));
    if (b != 0) begin
      check($sformatf("inv %0d/%0d", a, b), 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check($sformatf("rem_lt %0d/%0d", a, b), 32'(remainder < b), 32'd1);
    end
    check($sformatf("busy %0d/%0d", a, b), 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin in_valid = 1'b1; dividend = 8'd9; divisor = 4'd4; end
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quot", 32'(quotient), 32'(eq));
      check("hold_rem", 32'(remainder), 32'(er));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();                                         // handshake edge
    out_ready = keep_ready;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_quot", 32'(quotient), 32'(eq));
    prev_q = eq;
  endtask

  initial begin
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    do_op(8'd200, 4'd13, 0, 1'b0);
    do_op(8'd255, 4'd1,  0, 1'b0);
    do_op(8'd0,   4'd7,  0, 1'b0);
    do_op(8'd255, 4'd15, 0, 1'b0);
    do_op(8'd100, 4'd0,  0, 1'b0);
    do_op(8'd77,  4'd5,  6, 1'b1);

    // Abort mid-run: reset takes effect without waiting for a clock edge.
    in_valid = 1'b1; dividend = 8'd200; divisor = 4'd13;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_quot", 32'(quotient), 32'd0);
    #2 rst_n = 1'b1;
    prev_q = '0;
    tick();
    do_op(8'd9, 4'd4, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0);

    keep_ready = 1'b1;
    out_ready  = 1'b1;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        do_op(8'(a), 4'(b), 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
